// File: rtl/adam_aes_ctr_ctrl_if.sv
// Valid/ready block stream carrying one 128-bit AES block plus an end-of-message flag.
// The producer uses the master modport and the consumer uses the slave modport.
interface adam_aes_ctr_ctrl_if;
    logic         valid;
    logic         ready;
    logic [127:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/adam_aes_ctr_ctrl.sv
// CTR-mode sequencer for adam_aes_core: one block in flight, keystream = E(key, counter),
// out = in ^ keystream, then the low CTR_WIDTH bits of the counter increment.
module adam_aes_ctr_ctrl #(
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cfg_we_i,
    input  logic [127:0]         cfg_iv_i,
    input  logic [255:0]         cfg_key_i,
    input  logic                 cfg_keylen_i,

    adam_aes_ctr_ctrl_if.slave   in_if,
    adam_aes_ctr_ctrl_if.master  out_if,

    output logic                 core_start_o,
    output logic                 core_encdec_o,
    output logic [255:0]         core_key_o,
    output logic                 core_keylen_o,
    output logic [127:0]         core_block_o,
    input  logic                 core_ready_i,
    input  logic                 core_valid_i,
    input  logic [127:0]         core_result_i,

    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ctr_wrap_o
);

    // One extra bit so CTR_WIDTH == 128 yields an all-ones mask instead of overflowing.
    localparam logic [128:0] LOW_LIMIT = 129'd1 << CTR_WIDTH;
    localparam logic [127:0] LOW_MASK  = 128'(LOW_LIMIT - 129'd1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ACK,
        ST_WAIT,
        ST_OUT
    } state_e;

    state_e        state_q;
    logic [127:0]  ctr_q, ctr_d;
    logic [255:0]  key_q;
    logic          keylen_q;
    logic          wrap_q, wrap_d;
    logic          start_q;
    logic [127:0]  data_q;
    logic          last_q;
    logic [127:0]  out_data_q;
    logic          out_last_q;
    logic          out_valid_q;
    logic          in_hs;
    logic          out_hs;

    assign in_if.ready = (state_q == ST_IDLE) & core_ready_i;
    assign in_hs       = in_if.valid & in_if.ready;
    assign out_hs      = out_valid_q & out_if.ready;

    // Nonce bits pass through untouched; only the masked low field counts.
    assign ctr_d  = (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);
    assign wrap_d = ((ctr_q & LOW_MASK) == LOW_MASK);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            key_q       <= '0;
            keylen_q    <= 1'b0;
            wrap_q      <= 1'b0;
            start_q     <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_we_i) begin
                        ctr_q    <= cfg_iv_i;
                        key_q    <= cfg_key_i;
                        keylen_q <= cfg_keylen_i;
                        wrap_q   <= 1'b0;
                    end
                    if (in_hs) begin
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: state_q <= ST_ACK;
                // Core dropping ready proves it took the start, so a stale core_valid is ignored.
                ST_ACK: begin
                    if (!core_ready_i) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_ready_i && core_valid_i) begin
                        out_data_q  <= data_q ^ core_result_i;
                        out_last_q  <= last_q;
                        out_valid_q <= 1'b1;
                        ctr_q       <= ctr_d;
                        if (wrap_d) wrap_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_if.ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the input block buffer has no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            data_q <= in_if.data;
            last_q <= in_if.last;
        end
    end

    assign out_if.valid  = out_valid_q;
    assign out_if.data   = out_data_q;
    assign out_if.last   = out_last_q;

    assign core_start_o  = start_q;
    assign core_encdec_o = 1'b1;
    assign core_key_o    = key_q;
    assign core_keylen_o = keylen_q;
    assign core_block_o  = ctr_q;

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = out_hs & out_last_q;
    assign ctr_wrap_o    = wrap_q;

endmodule

// File: doc/adam_aes_ctr_ctrl.md
# adam_aes_ctr_ctrl

Counter-mode (CTR) sequencer for `adam_aes_core`. It accepts 128-bit data blocks over a valid/ready stream and drives one core encryption per block on the current counter value. It XORs the keystream with the data, presents the result on an output stream, and increments the counter. It sits between a DMA/stream source and the core, replacing register-poked single-block operation for bulk encrypt/decrypt (CTR decrypt is identical to encrypt).

## Interface
- `CTR_WIDTH`, default 32: number of low counter bits that increment; upper `128-CTR_WIDTH` bits hold the nonce and never change. Legal range 1..128.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: load `cfg_iv`, `cfg_key`, `cfg_keylen`; honoured only in IDLE, otherwise ignored.
- `cfg_iv` in 128: initial counter block.
- `cfg_key` in 256: key; a 128-bit key occupies [255:128].
- `cfg_keylen` in 1: 0 = AES-128, 1 = AES-256.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 128 / `in_last` in 1: input stream.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out 128 / `out_last` out 1: output stream.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_encdec` out 1: tied to 1 (encrypt).
- `core_key` out 256 / `core_keylen` out 1: the held configuration.
- `core_block` out 128: the current counter register.
- `core_ready` in 1 / `core_valid` in 1 / `core_result` in 128: core status and result.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when a block flagged `in_last` leaves the output stream.
- `ctr_wrap` out 1: sticky; set when the low field wraps, cleared by `cfg_we` or `rst`.

## Operation
- The FSM has five states: IDLE, START, ACK, WAIT, OUT.
- IDLE:
  - `in_ready = core_ready`.
  - On `in_valid & in_ready`, latch `in_data` and `in_last`, then go to START.
  - `cfg_we` in IDLE loads the counter, key and keylen, and clears `ctr_wrap`.
  - If `cfg_we` and an input handshake occur in the same cycle, the configuration is loaded first; the accepted block uses the new counter and key from START onward.
- START: assert `core_start` for exactly one cycle, then go to ACK.
- ACK: wait until `core_ready == 0`, meaning the core has taken the start. This stops a stale `core_valid` from the previous block being mistaken for the new result. Then go to WAIT.
- WAIT: when `core_ready & core_valid`, do all of the following in the same edge, then go to OUT:
  - `out_data_reg <= data_reg ^ core_result`.
  - `out_last_reg <= last_reg`.
  - Increment the counter.
- Counter increment:
  - Low `CTR_WIDTH` bits are incremented modulo 2^CTR_WIDTH.
  - The upper bits are unchanged.
  - A carry out of the low field sets `ctr_wrap`. Operation continues after a wrap; software decides whether that is an error.
- OUT:
  - `out_valid = 1` and `out_data`/`out_last` are held stable until `out_ready`.
  - On the handshake, go to IDLE; `done` pulses in the same cycle if `out_last`.
- `core_key`, `core_keylen` and `core_block` are stable from START until the WAIT exit.
- The counter persists across `in_last` boundaries; only `cfg_we` reloads it.

## Timing
- Reset values:
  - Outputs: `in_ready` follows `core_ready`; `out_valid`, `out_last`, `core_start`, `busy`, `done` and `ctr_wrap` are 0; `out_data` is 0.
  - Registers: counter, key and keylen are 0.
  - State: IDLE.
  - `core_encdec` is 1 always.
- Input handshake at cycle T gives START at T+1 (`core_start` high) and ACK from T+2.
- Result sampled at cycle W (WAIT with `core_ready & core_valid`) gives `out_valid` high at W+1.
- Throughput: one block per core latency + 4 cycles at most, when `out_ready` is held high. There is no overlap; one block is in flight at a time.
- Backpressure: an `out_ready` stall holds OUT indefinitely, and `in_ready` stays 0 meanwhile.
- `rst` mid-operation aborts immediately to IDLE with no output. The core is reset by its own reset, which is tied to the same system reset.

## Test plan
- CTR-AES128, NIST SP800-38A F.5.1:
  - Config: key `2b7e151628aed2a6abf7158809cf4f3c`, iv `f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff`.
  - Block 1: in `6bc1bee22e409f96e93d7e117393172a` -> out `874d6191b620e3261bef6864990db6ce`.
  - Block 2 (`in_last`=1): in `ae2d8a571e03ac9c9eb76fac45af8e51` -> out `9806f66b7970fdff8617187bb9fffdff`, with `done` pulsing once.
  - The counter after block 1 is `...fcfdff00`.
- Decrypt round-trip: feed the two ciphertexts with the same config -> the original plaintexts come out.
- Wrap: iv low field `ffffffff` (CTR_WIDTH=32), upper bits `0xA5...` -> after one block, counter low field is `00000000`, upper bits are unchanged, and `ctr_wrap` = 1. A following `cfg_we` clears it.
- Backpressure: `out_ready` low for 20 cycles -> `out_valid`/`out_data` are stable, `in_ready` = 0, and no second `core_start` occurs.
- `cfg_we` while busy is ignored (key and counter unchanged, result still matches the old key). `cfg_we` in IDLE with a simultaneous input handshake -> the block uses the new iv.
- `rst` asserted in WAIT -> next cycle: IDLE, `out_valid` = 0, counter = 0, no `done`; a subsequent full F.5.1 run still passes.
